aes_gcm_ctr_stage: RTL and testbench
====================================

# aes_gcm_ctr_stage

Second stage of the AES-GCM pipeline, directly downstream of the key-expansion / phase-generation stage. It registers the expanded key schedule and per-block data, builds the GCM pre-counter block J0 = IV || 0x00000001 at each new instance, and issues the per-text-block counter block IV || ctr32 for the AES round stages. It also tracks the block-phase sequence of each instance and raises the tag request on the final block.

## Interface
- J0_CTR, 32'h0000_0001, low-word value of J0 (96-bit IV case)
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  block present this cycle
- i_new_instance  in  1  first block of a new instance
- i_phase  in  [0:2]  010 AAD, 000 first text, 001 text, 011 last text, 111 first-and-last text
- i_key_schedule  in  [0:1407]  11 round keys
- i_plain_text, i_aad  in  [0:127] each  data blocks
- i_iv  in  [0:95]  IV, sampled only with i_new_instance
- i_instance_size  in  [0:127]  {text bits[0:63], aad bits[64:127]}
- i_pt_instance  in  1  passthrough tag
- o_valid  out  1  registered i_valid, gated by the drop rule
- o_key_schedule  out  [0:1407]  registered key schedule
- o_data_block  out  [0:127]  i_aad if phase 010, else i_plain_text
- o_is_aad  out  1  block is AAD
- o_ctr_block  out  [0:127]  {IV, ctr32 used}
- o_ctr_valid  out  1  o_valid and text block
- o_j0_block  out  [0:127]  {IV, J0_CTR} of current instance
- o_last, o_tag_req  out  1 each  final block of instance (phase 011/111)
- o_new_instance, o_pt_instance, o_instance_size  out  registered passthroughs
- o_seq_err  out  1  sticky phase-sequence violation
- o_ctr_wrap  out  1  sticky ctr32 wrap

## Operation
- States: IDLE, AAD, TEXT.
- IDLE: valid and new_instance with 010 go to AAD; with 000/001 go to TEXT; with 011/111 stay in IDLE (single-block instance).
- AAD: 010 stays; 000 goes to TEXT; 011/111 go to IDLE; 001 is illegal.
- TEXT: 001 stays; 011 goes to IDLE; 010/000/111 are illegal.
- Valid without new_instance in IDLE: illegal; block dropped (o_valid=0).
- new_instance in AAD/TEXT: illegal, instance abandoned, new instance accepted normally.
- Illegal transition (accepted block): o_seq_err set, block still forwarded, state follows the phase as if legal.
- ctr32 on a new instance: the used value is J0_CTR+1 (2), stored next value is 3 if the block is text, else 2.
- ctr32 otherwise: the used value is r_ctr; it increments by 1 mod 2^32 after each text block.
- Increment 0xFFFFFFFF to 0: o_ctr_wrap set (GCM inc32 semantics kept).
- AAD blocks: o_ctr_block carries the current value, o_ctr_valid=0.
- IV and J0 are held until the next new_instance.
- i_valid=0: state, ctr and IV are unchanged.

## Timing
- All outputs registered, 1-cycle latency from input sample.
- Reset values: every output 0, state IDLE, ctr 0, IV 0. The sticky flags clear only on rst.
- Reset takes priority over a simultaneous valid input, which is discarded.
- Reset mid-instance: first post-reset block must carry new_instance, or it is dropped.
- new_instance plus last phase in the same cycle: J0 loaded, used ctr=2, o_tag_req=1, state stays IDLE.
- Back-to-back instances, last block followed next cycle by a new_instance: no bubble.

## Configuration
- AES_GCM_SEQ_CHECK_EN defined: the illegal-transition detection above is compiled in and drives o_seq_err.
- Undefined: o_seq_err is tied to 0 and transitions follow the phase unconditionally.
- The drop rule (valid without new_instance in IDLE) and o_ctr_wrap are present in both builds.

## Structure
- Shared package aes_gcm_pkg holds:
  - the phase encoding constants PH_AAD, PH_FIRST, PH_TEXT, PH_LAST, PH_ONLY
  - the state enum typedef
  - the key schedule width constant (1408)
- One sub-module, aes_gcm_inc32: ctr32 increment with wrap-flag output.

## Test plan
- IV=0xCAFEBABEFACEDBADDECAF888, phases 010,000,001,011 -> o_ctr_block low words 2,2,3,4; o_j0_block low word 1; o_tag_req only on the 4th output; o_seq_err=0.
- Single block, new_instance with phase 111 -> o_ctr_block={IV,2}, o_ctr_valid=1, o_tag_req=1, state IDLE.
- Preload ctr to 0xFFFFFFFF via a long text run, one more text block -> low word 0xFFFFFFFF used, next block uses 0, o_ctr_wrap=1.
- Sequence 000 then 010 with the macro on -> o_seq_err=1 next cycle and stays high. Macro off -> remains 0.
- Reset asserted mid-TEXT, then a valid phase-001 block without new_instance -> o_valid stays 0. A following new_instance block -> o_valid=1, used ctr=2.
- rst and valid in the same cycle -> all outputs 0 the following cycle.

Source files
------------

// File: rtl/aes_gcm_pkg.sv
// Shared definitions for the AES-GCM pipeline: field widths, block-phase
// encoding, counter-stage state type and the phase-to-state mapping.
package aes_gcm_pkg;

    localparam int unsigned KS_W  = 1408;  // 11 round keys x 128 bits
    localparam int unsigned BLK_W = 128;
    localparam int unsigned IV_W  = 96;
    localparam int unsigned CTR_W = 32;
    localparam int unsigned PH_W  = 3;

    localparam logic [PH_W-1:0] PH_AAD   = 3'b010;
    localparam logic [PH_W-1:0] PH_FIRST = 3'b000;
    localparam logic [PH_W-1:0] PH_TEXT  = 3'b001;
    localparam logic [PH_W-1:0] PH_LAST  = 3'b011;
    localparam logic [PH_W-1:0] PH_ONLY  = 3'b111;

    // Low word of J0 for the 96-bit IV case
    localparam logic [CTR_W-1:0] J0_CTR = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AAD  = 2'd1,
        ST_TEXT = 2'd2
    } gcm_state_e;

    // Where an instance stands after a block of the given phase
    function automatic gcm_state_e phase_to_state(logic [PH_W-1:0] ph, gcm_state_e cur);
        case (ph)
            PH_AAD:            return ST_AAD;
            PH_FIRST, PH_TEXT: return ST_TEXT;
            PH_LAST, PH_ONLY:  return ST_IDLE;
            default:           return cur;
        endcase
    endfunction

endpackage

// File: rtl/aes_gcm_inc32.sv
// GCM inc32: increment of the 32-bit counter word modulo 2^32.
// Ports: ctr (current word) -> ctr_inc_c (ctr+1 mod 2^32), wrap_c (ctr was all ones).
module aes_gcm_inc32
    import aes_gcm_pkg::*;
(
    input  logic [CTR_W-1:0] ctr,
    output logic [CTR_W-1:0] ctr_inc_c,
    output logic             wrap_c
);

    assign {wrap_c, ctr_inc_c} = (CTR_W+1)'(ctr) + (CTR_W+1)'(1);

endmodule

// File: rtl/aes_gcm_ctr_stage.sv
// AES-GCM counter stage: registers the key schedule and data block, builds
// J0 = IV || J0 low word per instance and issues IV || ctr32 per text block.
// Tracks the block-phase sequence and flags the final block (tag request).
// Ports: clk, rst (sync, active high); i_* block inputs; o_* registered
// block outputs, o_seq_err / o_ctr_wrap sticky status flags.
// Build option: AES_GCM_SEQ_CHECK_EN compiles in the phase-sequence checker
// driving o_seq_err; otherwise o_seq_err is held at 0.
module aes_gcm_ctr_stage
    import aes_gcm_pkg::*;
#(
    parameter logic [CTR_W-1:0] J0_INIT = J0_CTR  // J0 low word
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_new_instance,
    input  logic [0:PH_W-1]   i_phase,
    input  logic [0:KS_W-1]   i_key_schedule,
    input  logic [0:BLK_W-1]  i_plain_text,
    input  logic [0:BLK_W-1]  i_aad,
    input  logic [0:IV_W-1]   i_iv,
    input  logic [0:BLK_W-1]  i_instance_size,
    input  logic              i_pt_instance,
    output logic              o_valid,
    output logic [0:KS_W-1]   o_key_schedule,
    output logic [0:BLK_W-1]  o_data_block,
    output logic              o_is_aad,
    output logic [0:BLK_W-1]  o_ctr_block,
    output logic              o_ctr_valid,
    output logic [0:BLK_W-1]  o_j0_block,
    output logic              o_last,
    output logic              o_tag_req,
    output logic              o_new_instance,
    output logic              o_pt_instance,
    output logic [0:BLK_W-1]  o_instance_size,
    output logic              o_seq_err,
    output logic              o_ctr_wrap
);

    gcm_state_e        r_state;
    logic [0:IV_W-1]   r_iv;
    logic [CTR_W-1:0]  r_ctr;

    logic              accept_c;
    logic              is_text_c;
    logic              is_last_c;
    logic [0:IV_W-1]   iv_use_c;
    logic [CTR_W-1:0]  ctr_use_c;
    logic [CTR_W-1:0]  ctr_inc_c;
    logic              inc_wrap_c;
    gcm_state_e        state_next_c;

    // Block acceptance, counter selection and next state
    always_comb begin
        // Outside an instance only a block opening a new instance is taken
        accept_c     = i_valid && (i_new_instance || (r_state != ST_IDLE));
        is_text_c    = (i_phase != PH_AAD);
        is_last_c    = (i_phase == PH_LAST) || (i_phase == PH_ONLY);
        iv_use_c     = i_new_instance ? i_iv : r_iv;
        ctr_use_c    = i_new_instance ? (J0_INIT + CTR_W'(1)) : r_ctr;
        state_next_c = phase_to_state(i_phase, r_state);
    end

`ifdef AES_GCM_SEQ_CHECK_EN
    logic seq_bad_c;

    // Illegal phase for the current state, or instance abandoned mid-way
    always_comb begin
        seq_bad_c = 1'b0;
        case (r_state)
            ST_AAD:  seq_bad_c = i_new_instance ||
                                 !(i_phase inside {PH_AAD, PH_FIRST, PH_LAST, PH_ONLY});
            ST_TEXT: seq_bad_c = i_new_instance ||
                                 !(i_phase inside {PH_TEXT, PH_LAST});
            default: seq_bad_c = 1'b0;
        endcase
    end
`endif

    aes_gcm_inc32 u_inc32 (
        .ctr       (ctr_use_c),
        .ctr_inc_c (ctr_inc_c),
        .wrap_c    (inc_wrap_c)
    );

    // State, counter, IV and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_iv            <= '0;
            r_ctr           <= '0;
            o_valid         <= 1'b0;
            o_key_schedule  <= '0;
            o_data_block    <= '0;
            o_is_aad        <= 1'b0;
            o_ctr_block     <= '0;
            o_ctr_valid     <= 1'b0;
            o_j0_block      <= '0;
            o_last          <= 1'b0;
            o_tag_req       <= 1'b0;
            o_new_instance  <= 1'b0;
            o_pt_instance   <= 1'b0;
            o_instance_size <= '0;
            o_seq_err       <= 1'b0;
            o_ctr_wrap      <= 1'b0;
        end else begin
            o_valid        <= accept_c;
            o_ctr_valid    <= accept_c && is_text_c;
            o_last         <= accept_c && is_last_c;
            o_tag_req      <= accept_c && is_last_c;
            o_new_instance <= accept_c && i_new_instance;
            if (accept_c) begin
                r_state         <= state_next_c;
                r_iv            <= iv_use_c;
                o_key_schedule  <= i_key_schedule;
                o_data_block    <= is_text_c ? i_plain_text : i_aad;
                o_is_aad        <= !is_text_c;
                o_ctr_block     <= {iv_use_c, ctr_use_c};
                o_j0_block      <= {iv_use_c, J0_INIT};
                o_pt_instance   <= i_pt_instance;
                o_instance_size <= i_instance_size;
                // AAD blocks do not consume a counter value
                if (is_text_c) begin
                    r_ctr      <= ctr_inc_c;
                    o_ctr_wrap <= o_ctr_wrap | inc_wrap_c;
                end else begin
                    r_ctr      <= ctr_use_c;
                end
`ifdef AES_GCM_SEQ_CHECK_EN
                o_seq_err <= o_seq_err | seq_bad_c;
`else
                o_seq_err <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_aes_gcm_ctr_stage.sv
// Self-checking bench for aes_gcm_ctr_stage: directed scenarios plus random
// block streams compared against a behavioural model of the counter stage.
module tb_aes_gcm_ctr_stage;

    logic          clk = 1'b0;
    logic          rst;
    logic          rst_w;
    logic          i_valid;
    logic          i_new_instance;
    logic [0:2]    i_phase;
    logic [0:1407] i_key_schedule;
    logic [0:127]  i_plain_text;
    logic [0:127]  i_aad;
    logic [0:95]   i_iv;
    logic [0:127]  i_instance_size;
    logic          i_pt_instance;

    logic          o_valid, o_is_aad, o_ctr_valid, o_last, o_tag_req;
    logic          o_new_instance, o_pt_instance, o_seq_err, o_ctr_wrap;
    logic [0:1407] o_key_schedule;
    logic [0:127]  o_data_block, o_ctr_block, o_j0_block, o_instance_size;

    logic          w_valid, w_is_aad, w_ctr_valid, w_last, w_tag_req;
    logic          w_new_instance, w_pt_instance, w_seq_err, w_ctr_wrap;
    logic [0:1407] w_key_schedule;
    logic [0:127]  w_data_block, w_ctr_block, w_j0_block, w_instance_size;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aes_gcm_ctr_stage dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_new_instance(i_new_instance),
        .i_phase(i_phase), .i_key_schedule(i_key_schedule), .i_plain_text(i_plain_text),
        .i_aad(i_aad), .i_iv(i_iv), .i_instance_size(i_instance_size),
        .i_pt_instance(i_pt_instance), .o_valid(o_valid), .o_key_schedule(o_key_schedule),
        .o_data_block(o_data_block), .o_is_aad(o_is_aad), .o_ctr_block(o_ctr_block),
        .o_ctr_valid(o_ctr_valid), .o_j0_block(o_j0_block), .o_last(o_last),
        .o_tag_req(o_tag_req), .o_new_instance(o_new_instance),
        .o_pt_instance(o_pt_instance), .o_instance_size(o_instance_size),
        .o_seq_err(o_seq_err), .o_ctr_wrap(o_ctr_wrap)
    );

    // Second instance with J0 low word near the top of the 32-bit range
    aes_gcm_ctr_stage #(.J0_INIT(32'hFFFF_FFFD)) dut_w (
        .clk(clk), .rst(rst_w), .i_valid(i_valid), .i_new_instance(i_new_instance),
        .i_phase(i_phase), .i_key_schedule(i_key_schedule), .i_plain_text(i_plain_text),
        .i_aad(i_aad), .i_iv(i_iv), .i_instance_size(i_instance_size),
        .i_pt_instance(i_pt_instance), .o_valid(w_valid), .o_key_schedule(w_key_schedule),
        .o_data_block(w_data_block), .o_is_aad(w_is_aad), .o_ctr_block(w_ctr_block),
        .o_ctr_valid(w_ctr_valid), .o_j0_block(w_j0_block), .o_last(w_last),
        .o_tag_req(w_tag_req), .o_new_instance(w_new_instance),
        .o_pt_instance(w_pt_instance), .o_instance_size(w_instance_size),
        .o_seq_err(w_seq_err), .o_ctr_wrap(w_ctr_wrap)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural model: instance position (0 none, 1 in AAD, 2 in text)
    int          m_mode;
    logic [0:95] m_iv;
    longint      m_ctr;
    logic        m_seq, m_wrap;

    logic          e_valid, e_text, e_last, e_ni, e_pt;
    logic [0:127]  e_ctr, e_j0, e_data, e_size;
    logic [0:1407] e_key;

    function automatic int mode_after(logic [2:0] ph);
        case (ph)
            3'b010:         return 1;
            3'b000, 3'b001: return 2;
            default:        return 0;
        endcase
    endfunction

    function automatic logic phase_ok(int mode, logic [2:0] ph);
        if (mode == 1) return ph == 3'b010 || ph == 3'b000 || ph == 3'b011 || ph == 3'b111;
        if (mode == 2) return ph == 3'b001 || ph == 3'b011;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_iv = '0; m_ctr = 0; m_seq = 1'b0; m_wrap = 1'b0;
    endtask

    // One clock: apply inputs, predict, then check outputs on the falling edge
    task automatic drive(input logic v, input logic ni, input logic [2:0] ph,
                         input logic r, input logic [95:0] iv);
        longint used;
        logic   bad;
        for (int k = 0; k < 44; k++) i_key_schedule[k*32 +: 32] = $urandom();
        i_plain_text    = {$urandom(), $urandom(), $urandom(), $urandom()};
        i_aad           = {$urandom(), $urandom(), $urandom(), $urandom()};
        i_instance_size = {$urandom(), $urandom(), $urandom(), $urandom()};
        i_pt_instance   = 1'($urandom_range(0, 1));
        i_iv = iv; i_valid = v; i_new_instance = ni; i_phase = ph; rst = r;
        e_valid = 1'b0;
        if (r) begin
            model_reset();
        end else if (v && (ni || m_mode != 0)) begin
            e_valid = 1'b1;
            e_text  = (ph != 3'b010);
            e_last  = (ph == 3'b011) || (ph == 3'b111);
            e_ni = ni; e_pt = i_pt_instance; e_size = i_instance_size;
            e_key = i_key_schedule;
            e_data = e_text ? i_plain_text : i_aad;
            if (ni) begin
                bad = (m_mode != 0); m_iv = iv; used = 2;
            end else begin
                bad = !phase_ok(m_mode, ph); used = m_ctr;
            end
`ifdef AES_GCM_SEQ_CHECK_EN
            if (bad) m_seq = 1'b1;
`endif
            if (e_text) begin
                if (used == 64'hFFFF_FFFF) m_wrap = 1'b1;
                m_ctr = (used + 1) % 64'h1_0000_0000;
            end else begin
                m_ctr = used;
            end
            m_mode = mode_after(ph);
            e_ctr = {m_iv, 32'(used)};
            e_j0  = {m_iv, 32'h0000_0001};
        end
        @(posedge clk);
        @(negedge clk);
        check("valid", 128'(o_valid), 128'(e_valid));
        check("seq_err", 128'(o_seq_err), 128'(m_seq));
        check("ctr_wrap", 128'(o_ctr_wrap), 128'(m_wrap));
        if (r) begin
            check("rst_ctr", o_ctr_block, '0);
            check("rst_j0", o_j0_block, '0);
            check("rst_tag", 128'(o_tag_req), '0);
        end else if (e_valid) begin
            check("ctr_block", o_ctr_block, e_ctr);
            check("j0_block", o_j0_block, e_j0);
            check("data", o_data_block, e_data);
            check("is_aad", 128'(o_is_aad), 128'(!e_text));
            check("ctr_valid", 128'(o_ctr_valid), 128'(e_text));
            check("last", 128'(o_last), 128'(e_last));
            check("tag_req", 128'(o_tag_req), 128'(e_last));
            check("new_inst", 128'(o_new_instance), 128'(e_ni));
            check("pt_inst", 128'(o_pt_instance), 128'(e_pt));
            check("size", o_instance_size, e_size);
            check("key_lo", o_key_schedule[0:127], e_key[0:127]);
            check("key_hi", o_key_schedule[1280:1407], e_key[1280:1407]);
        end else begin
            check("ctr_valid_idle", 128'(o_ctr_valid), '0);
            check("tag_idle", 128'(o_tag_req), '0);
        end
    endtask

    localparam logic [95:0] IVC = 96'hCAFEBABE_FACEDBAD_DECAF888;
    localparam logic [2:0]  PHS [5] = '{3'b010, 3'b000, 3'b001, 3'b011, 3'b111};

    initial begin
        logic exp_seq;
        rst_w = 1'b1;
        model_reset();
        @(negedge clk);
        drive(0, 0, 3'b000, 1, '0);
        drive(0, 0, 3'b000, 1, '0);
        check("rst_valid", 128'(o_valid), '0);
        check("rst_key", o_key_schedule[0:127], '0);

        // Four-block instance: AAD, first, text, last
        drive(1, 1, 3'b010, 0, IVC);
        check("tp_ctr0", 128'(o_ctr_block[96:127]), 128'd2);
        check("tp_j0", o_j0_block, {IVC, 32'h1});
        check("tp_ctrv0", 128'(o_ctr_valid), '0);
        drive(1, 0, 3'b000, 0, '0);
        check("tp_ctr1", 128'(o_ctr_block[96:127]), 128'd2);
        drive(1, 0, 3'b001, 0, '0);
        check("tp_ctr2", 128'(o_ctr_block[96:127]), 128'd3);
        check("tp_tag2", 128'(o_tag_req), '0);
        drive(1, 0, 3'b011, 0, '0);
        check("tp_ctr3", o_ctr_block, {IVC, 32'd4});
        check("tp_tag3", 128'(o_tag_req), 128'd1);
        check("tp_seq", 128'(o_seq_err), '0);

        // Single-block instance, back to back with the previous one
        drive(1, 1, 3'b111, 0, ~IVC);
        check("one_ctr", o_ctr_block, {~IVC, 32'd2});
        check("one_ctrv", 128'(o_ctr_valid), 128'd1);
        check("one_tag", 128'(o_tag_req), 128'd1);
        drive(1, 0, 3'b001, 0, '0);
        check("one_idle_drop", 128'(o_valid), '0);

        // Illegal 000 -> 010 sequence
`ifdef AES_GCM_SEQ_CHECK_EN
        exp_seq = 1'b1;
`else
        exp_seq = 1'b0;
`endif
        drive(1, 1, 3'b000, 0, IVC);
        drive(1, 0, 3'b010, 0, '0);
        check("seq_set", 128'(o_seq_err), 128'(exp_seq));
        drive(1, 0, 3'b011, 0, '0);
        check("seq_sticky", 128'(o_seq_err), 128'(exp_seq));

        // Reset mid-TEXT, then a block without new_instance
        drive(1, 1, 3'b000, 0, IVC);
        drive(1, 0, 3'b001, 0, '0);
        drive(0, 0, 3'b001, 1, '0);
        drive(1, 0, 3'b001, 0, '0);
        check("mid_rst_drop", 128'(o_valid), '0);
        drive(1, 1, 3'b001, 0, IVC);
        check("mid_rst_new", 128'(o_valid), 128'd1);
        check("mid_rst_ctr", 128'(o_ctr_block[96:127]), 128'd2);

        // Reset together with a valid block
        drive(1, 1, 3'b111, 1, IVC);
        check("rv_valid", 128'(o_valid), '0);
        check("rv_data", o_data_block, '0);
        check("rv_size", o_instance_size, '0);

        // Counter wrap on the high-J0 instance
        rst_w = 1'b0;
        drive(1, 1, 3'b000, 0, IVC);
        check("w_ctr0", 128'(w_ctr_block[96:127]), 128'hFFFF_FFFE);
        check("w_wrap0", 128'(w_ctr_wrap), '0);
        drive(1, 0, 3'b001, 0, '0);
        check("w_ctr1", 128'(w_ctr_block[96:127]), 128'hFFFF_FFFF);
        check("w_wrap1", 128'(w_ctr_wrap), 128'd1);
        drive(1, 0, 3'b011, 0, '0);
        check("w_ctr2", w_ctr_block, {IVC, 32'd0});
        check("w_wrap2", 128'(w_ctr_wrap), 128'd1);
        check("w_j0", w_j0_block, {IVC, 32'hFFFF_FFFD});
        rst_w = 1'b1;

        // Random block streams
        for (int n = 0; n < 3000; n++) begin
            logic v, ni, r;
            v  = ($urandom_range(0, 99) < 85);
            ni = (m_mode == 0) ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 10);
            r  = ($urandom_range(0, 199) == 0);
            drive(v, ni, PHS[$urandom_range(0, 4)], r,
                  {$urandom(), $urandom(), $urandom()});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
